// File: rtl/mic_dma_sched_if.sv
// CSR slave and mic_dma control bundle for the ping-pong capture scheduler.
interface mic_dma_sched_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        dma_start;
  logic [31:0] dma_start_address;
  logic [31:0] dma_number_samples;
  logic        dma_finished;
  logic        irq;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, dma_finished,
    output avs_readdata, dma_start, dma_start_address, dma_number_samples, irq
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, dma_finished,
    input  avs_readdata, dma_start, dma_start_address, dma_number_samples, irq
  );
endinterface

// File: rtl/mic_dma_sched.sv
// Ping-pong capture scheduler: alternates mic_dma transfers between buffers A/B,
// flags filled buffers via CSR STATUS and a level interrupt.
module mic_dma_sched #(
  parameter int unsigned CNT_W      = 8,
  parameter logic [31:0] DEF_NSAMP  = 32'd256
) (
  input  logic CLK,
  input  logic RESET,
  mic_dma_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_GUARD,
    S_BUSY,
    S_COMPLETE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_en;
  logic               r_oneshot;
  logic [31:0]        r_base_a;
  logic [31:0]        r_base_b;
  logic [31:0]        r_nsamp;
  logic [1:0]         r_rdy;
  logic               r_cur;
  logic [CNT_W-1:0]   r_ovr;
  logic               r_start;
  logic [31:0]        r_addr;
  logic [31:0]        r_nsamp_out;
  logic [31:0]        r_rdata;
  logic               r_irq;

  logic               w_complete;
  logic               w_busy;
  logic [1:0]         w_ack_mask;
  logic [1:0]         w_set_mask;
  logic [1:0]         w_rdy_nxt;
  logic               w_cur_nxt;
  logic               w_ovr_hit;
  logic [7:0]         w_ovr8;
  logic [31:0]        w_status;
  logic [31:0]        w_rmux;
  logic               w_wr_ctrl;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (r_en && (r_nsamp != '0)) w_next = S_START;
      S_START:    w_next = S_GUARD;
      // FINISHED may still be high from the previous run here
      S_GUARD:    w_next = S_BUSY;
      S_BUSY:     if (bus.dma_finished) w_next = S_COMPLETE;
      S_COMPLETE: w_next = (r_en && !r_oneshot) ? S_START : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_complete = (r_state == S_COMPLETE);
    w_busy     = (r_state != S_IDLE);
    w_wr_ctrl  = bus.avs_write && (bus.avs_address == 3'd0);
    w_ack_mask = (bus.avs_write && (bus.avs_address == 3'd5)) ? bus.avs_writedata[1:0] : 2'b00;
    w_set_mask = w_complete ? (r_cur ? 2'b10 : 2'b01) : 2'b00;
    // set beats a same-cycle ACK; overrun is judged on the pre-ACK flag
    w_rdy_nxt  = (r_rdy & ~w_ack_mask) | w_set_mask;
    w_cur_nxt  = w_complete ? ~r_cur : r_cur;
    w_ovr_hit  = w_complete && (r_cur ? r_rdy[1] : r_rdy[0]);
    w_ovr8     = 8'(r_ovr);
    w_status   = {16'h0000, w_ovr8, 4'h0, r_cur, w_busy, r_rdy};
    case (bus.avs_address)
      3'd0:    w_rmux = {30'd0, r_oneshot, r_en};
      3'd1:    w_rmux = r_base_a;
      3'd2:    w_rmux = r_base_b;
      3'd3:    w_rmux = r_nsamp;
      3'd4:    w_rmux = w_status;
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_en        <= 1'b0;
      r_oneshot   <= 1'b0;
      r_base_a    <= '0;
      r_base_b    <= '0;
      r_nsamp     <= DEF_NSAMP;
      r_rdy       <= '0;
      r_cur       <= 1'b0;
      r_ovr       <= '0;
      r_start     <= 1'b0;
      r_addr      <= '0;
      r_nsamp_out <= '0;
      r_rdata     <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy   <= w_rdy_nxt;
      r_irq   <= |w_rdy_nxt;
      r_cur   <= w_cur_nxt;
      r_start <= (w_next == S_START);

      if (w_ovr_hit && (r_ovr != '1))
        r_ovr <= r_ovr + CNT_W'(1);

      if (w_wr_ctrl) begin
        r_en      <= bus.avs_writedata[0];
        r_oneshot <= bus.avs_writedata[1];
      end else if (w_complete && r_oneshot) begin
        r_en <= 1'b0;
      end

      if (bus.avs_write && (bus.avs_address == 3'd1)) r_base_a <= bus.avs_writedata;
      if (bus.avs_write && (bus.avs_address == 3'd2)) r_base_b <= bus.avs_writedata;
      if (bus.avs_write && (bus.avs_address == 3'd3)) r_nsamp  <= bus.avs_writedata;

      // latched on entry so address/count are valid during the start pulse
      if (w_next == S_START) begin
        r_addr      <= w_cur_nxt ? r_base_b : r_base_a;
        r_nsamp_out <= r_nsamp;
      end

      if (bus.avs_read) r_rdata <= w_rmux;
    end
  end

  assign bus.avs_readdata       = r_rdata;
  assign bus.dma_start          = r_start;
  assign bus.dma_start_address  = r_addr;
  assign bus.dma_number_samples = r_nsamp_out;
  assign bus.irq                = r_irq;

endmodule
